// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : oversampling asynchronous serial receiver.
//   Detects a start bit on RX_IN and samples each bit in the middle of its
//   period. Data is deserialized LSB first. Optional parity and the stop bit
//   are checked. The result is reported with one-cycle pulses.
//   Frame: start(0), Data_Len data bits LSB first, [parity], stop(1).
// Ports:
//   CLK        in  oversampling clock, rising edge
//   RST        in  synchronous active-high reset
//   RX_IN      in  serial line (idle high), already synchronized to CLK
//   PAR_EN     in  frame carries a parity bit
//   PAR_TYP    in  0 even parity, 1 odd parity
//   Prescale   in  clocks per bit (even, >= 8)
//   P_DATA     out last error-free received word
//   Data_Valid out 1-cycle pulse, P_DATA updated
//   Par_err    out 1-cycle pulse, parity mismatch
//   Stp_err    out 1-cycle pulse, stop bit sampled 0
// Build option:
//   UART_RX_MAJORITY_EN  2-of-3 vote of samples at P/2-1, P/2, P/2+1
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned Data_Len   = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [Data_Len-1:0]   P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int unsigned BCW = $clog2(Data_Len) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] r_presc;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;
  logic [Data_Len-1:0]   r_shift;
  logic                  r_smp_mid;

  logic [PRESCALE_W-1:0] w_half;
  logic                  w_last;
  logic                  w_bit;
  logic                  w_par_exp;

  assign w_half    = r_presc >> 1;
  assign w_last    = (r_edge_cnt == (r_presc - PRESCALE_W'(1)));
  assign w_par_exp = r_par_typ ? ~(^r_shift) : (^r_shift);

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_lo;
  logic r_smp_hi;

  // Three samples around mid-bit. All of them come before the decision edge because P >= 8.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_smp_lo  <= 1'b0;
      r_smp_mid <= 1'b0;
      r_smp_hi  <= 1'b0;
    end else begin
      if (r_edge_cnt == (w_half - PRESCALE_W'(1))) r_smp_lo  <= RX_IN;
      if (r_edge_cnt == w_half)                    r_smp_mid <= RX_IN;
      if (r_edge_cnt == (w_half + PRESCALE_W'(1))) r_smp_hi  <= RX_IN;
    end
  end

  assign w_bit = (r_smp_lo & r_smp_mid) | (r_smp_lo & r_smp_hi) | (r_smp_mid & r_smp_hi);
`else
  // Single sample at mid-bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_smp_mid <= 1'b0;
    end else if (r_edge_cnt == w_half) begin
      r_smp_mid <= RX_IN;
    end
  end

  assign w_bit = r_smp_mid;
`endif

  // Frame FSM. Bit decisions are taken on the last edge of each bit period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_presc    <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_shift    <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;

      if (r_state != S_IDLE) begin
        r_edge_cnt <= w_last ? '0 : (r_edge_cnt + PRESCALE_W'(1));
      end

      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          // The detect cycle is edge 0 of the start bit, so counting resumes at 1.
          if (!RX_IN) begin
            r_state    <= S_START;
            r_edge_cnt <= PRESCALE_W'(1);
            r_presc    <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_fail <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (w_last) begin
            r_bit_cnt <= '0;
            r_state   <= w_bit ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_last) begin
            // Bits enter at the MSB end. After Data_Len shifts the first bit sits at bit 0.
            r_shift   <= {w_bit, r_shift[Data_Len-1:1]};
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            if (r_bit_cnt == BCW'(Data_Len - 1)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (w_last) begin
            r_par_fail <= (w_bit != w_par_exp);
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_last) begin
            r_state <= S_IDLE;
            Stp_err <= ~w_bit;
            Par_err <= r_par_fail;
            if (w_bit && !r_par_fail) begin
              Data_Valid <= 1'b1;
              P_DATA     <= r_shift;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx.
//   The driver serializes frames and queues the expected report for each one.
//   The expected report is derived from the frame contents. The monitor pops
//   an entry whenever the receiver pulses an output and compares all fields.
// ----------------------------------------------------------------------------
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_err;
  logic       Stp_err;

`ifdef UART_RX_MAJORITY_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  uart_rx #(.Data_Len(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Par_err(Par_err), .Stp_err(Stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_pdata;
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: each reporting pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (Data_Valid || Par_err || Stp_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("Data_Valid", int'(Data_Valid), int'(e.dv));
        check("Par_err", int'(Par_err), int'(e.pe));
        check("Stp_err", int'(Stp_err), int'(e.se));
        check("P_DATA", int'(P_DATA), int'(e.pd));
      end
    end
  end

  // One bit period. Optionally flips the line for the single cycle at mid-bit.
  task automatic send_bit(input bit b, input int p, input bit g);
    if (g) begin
      RX_IN = b;
      repeat (p / 2) @(posedge CLK);
      #1 RX_IN = ~b;
      @(posedge CLK);
      #1 RX_IN = b;
      repeat (p - p / 2 - 1) @(posedge CLK);
      #1;
    end else begin
      RX_IN = b;
      repeat (p) @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference model: the outcome depends only on what was put on the line.
  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit bad_par, input bit stop_b, input bit scramble, input bit g);
    exp_t e;
    bit   pbit;
    int   n;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    Prescale = 6'(p);
    // Parity bit that makes the count of ones even (even) or odd (odd).
    pbit = bit'(($countones(d) + int'(ptyp)) % 2);
    if (bad_par) pbit = ~pbit;
    n = 10 + int'(pen);
    e.cyc = cyc + n * p;
    e.pe  = pen && bad_par;
    e.se  = !stop_b;
    e.dv  = !(e.pe || e.se);
    if (e.dv) m_pdata = d;
    e.pd = m_pdata;
    sb.push_back(e);
    send_bit(1'b0, p, g);
    if (scramble) begin
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
      Prescale = 6'(8 << $urandom_range(0, 2));
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p, g);
    if (pen) send_bit(pbit, p, g);
    send_bit(stop_b, p, g);
    RX_IN = 1'b1;
  endtask

  initial begin
    exp_t e;
    RST      = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    m_pdata  = 8'h00;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_P_DATA", int'(P_DATA), 0);
    check("reset_Data_Valid", int'(Data_Valid), 0);
    check("reset_Par_err", int'(Par_err), 0);
    check("reset_Stp_err", int'(Stp_err), 0);
    @(posedge CLK);
    #1;

    // Basic frame, then even parity good and bad, then a bad stop bit.
    send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(8, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // False start: three low cycles then high.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(16);
    send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Back-to-back frames with no idle gap.
    send_frame(32, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(32, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Break: line held low for a whole frame, then released after the report.
    // The start that is detected again while the line is low then fails as a false start.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    e.cyc = cyc + 80;
    e.dv  = 1'b0;
    e.pe  = 1'b0;
    e.se  = 1'b1;
    e.pd  = m_pdata;
    sb.push_back(e);
    RX_IN = 1'b0;
    repeat (81) @(posedge CLK);
    #1;
    idle(20);

    // Reset in the middle of the data bits of a frame.
    send_bit(1'b0, 8, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 8, 1'b0);
    RST   = 1'b1;
    RX_IN = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("midreset_P_DATA", int'(P_DATA), 0);
    check("midreset_Data_Valid", int'(Data_Valid), 0);
    check("midreset_Par_err", int'(Par_err), 0);
    check("midreset_Stp_err", int'(Stp_err), 0);
    m_pdata = 8'h00;
    idle(20);
    send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, GLITCH);
    idle(3);

    // Randomized frames. Config is scrambled mid-frame and errors are injected.
    for (int k = 0; k < 24; k++) begin
      send_frame(8 << $urandom_range(0, 2), 1'($urandom), 1'($urandom), 8'($urandom),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, 1'b1, 1'b0);
      idle($urandom_range(0, 3));
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    idle(10);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
